spi_slave_regs: RTL
===================

Name: spi_slave_regs

Overview:
- Synthesizable SPI Mode 0 slave (CPOL=0, CPHA=0) on the Zybo Z7-20 FPGA.
- Responder to the ESP32 SPI master: decodes the frame `{cmd, addr, payload}` sent MSB first and services a small bank of brightness registers.
- Write frames update a register. Read frames return a register value on miso during the payload phase.
- All SPI inputs are oversampled in the sysclk domain. No logic is clocked by sclk.

Parameters:
- CMD_BITS, 1, command field width; 1 = write, 0 = read.
- ADDR_BITS, 8, address field width.
- PAYLOAD_BITS, 7, payload width (equals BRIGHTNESS_WIDTH).
- NUM_REGS, 4, number of implemented registers; addresses ≥ NUM_REGS are out of range.
- SYNC_STAGES, 2, synchronizer depth for sclk, cs, mosi (minimum 2).

Ports:
- sysclk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous reset, active-high.
- sclk  in  1  SPI clock from master, asynchronous to sysclk.
- cs  in  1  chip select, active low.
- mosi  in  1  master-out serial data.
- miso  out  1  slave-out serial data.
- reg_bank  out  NUM_REGS*PAYLOAD_BITS  flattened register contents; reg i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- wr_stb  out  1  one-cycle pulse when a register is written.
- wr_addr  out  ADDR_BITS  address of last write.
- wr_data  out  PAYLOAD_BITS  data of last write.
- frame_done  out  1  one-cycle pulse on completion of any full frame.
- frame_err  out  1  one-cycle pulse on out-of-range address or aborted frame.

Behaviour:
- Reset state:
  - All outputs are 0.
  - All registers are 0.
  - FSM is in IDLE.
  - Synchronizers are set to the idle level: cs=1, sclk=0, mosi=0.
- Input synchronization and edge detection:
  - sclk, cs and mosi each pass through SYNC_STAGES flip-flops.
  - Edges are detected against one further delayed copy.
  - Rise and fall flags are each one sysclk wide.
- Sampling and drive: mosi is sampled on the sclk rise flag; miso is updated on the sclk fall flag.
- sclk constraint: sclk high and low times are each ≥ 2 sysclk periods, or sclk pulses are ≥ 1 sysclk wide with period ≥ 4 sysclk.
- FSM states:
  - IDLE: wait for the cs falling flag → CMD. Bit counter cleared, shift registers cleared, miso=0.
  - CMD: shift CMD_BITS bits on rise flags → ADDR.
  - ADDR: shift ADDR_BITS bits. On the rise flag of the last address bit, move to DATA.
    - Read with in-range address: load the tx shift register with reg[addr].
    - Read with out-of-range address: load 0.
    - Next sysclk cycle: miso <= tx MSB.
  - DATA: shift PAYLOAD_BITS bits from mosi. For reads, each fall flag shifts tx left and miso <= new MSB. The rise flag of the last payload bit → DONE.
  - DONE (single cycle), then → IDLE:
    - frame_done=1.
    - Write with in-range address: reg[addr] <= payload, wr_stb=1, wr_addr and wr_data updated.
    - Out-of-range address: frame_err=1 and no register changes; this applies to reads as well as writes.
    - miso <= 0.
- Bit counter is sized for max(CMD_BITS, ADDR_BITS, PAYLOAD_BITS) and clears on every state change.
- Abort: a cs rising flag in CMD, ADDR or DATA gives frame_err=1 for one cycle, a return to IDLE, and no register write. The abort takes priority over a same-cycle rise flag.
- Extra sclk after DONE: sclk edges while cs is still low and the FSM is in IDLE after DONE are ignored. A new frame requires a cs high→low transition.
- Reset mid-frame: immediate return to the reset state. Registers are cleared and no pulse outputs are asserted.
- Ignored inputs: sclk edges while cs is high are ignored. mosi content in IDLE is don't-care, including X.
- wr_addr/wr_data hold their values until the next write.

Optional Feature:
- Macro: SPI_SLAVE_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt [7:0], reset 0.
  - err_cnt increments on every frame_err pulse and saturates at 8'hFF.
  - A write to address NUM_REGS, otherwise out of range, clears err_cnt. This write does not itself count as an error and produces frame_done without wr_stb.
- When undefined: no port, no counter, and address NUM_REGS behaves like any other out-of-range address.

Test Plan:
1. Write reg 2: frame cmd=1, addr=0x02, payload=0x55 → one wr_stb with wr_addr=0x02 and wr_data=0x55; reg_bank[20:14]=0x55; one frame_done.
2. Read back: after test 1, frame cmd=0, addr=0x02, payload=0x00 → miso shifts 1010101 MSB first, sampled on master rising edges; no wr_stb; reg_bank unchanged.
3. Out of range: write addr=0x09, payload=0x7F → frame_err=1 and frame_done=1, no wr_stb, reg_bank unchanged. Read addr=0x09 → miso all zero.
4. Abort: raise cs after 4 address bits → frame_err pulse, FSM in IDLE. The next full write frame to addr 0x01 with payload 0x12 succeeds.
5. Reset: assert rst for 1 cycle during the DATA phase of a write to addr 0 → reg_bank=0, no wr_stb or frame_done. Subsequent frames work.
6. Back-to-back: four consecutive write frames to addresses 0–3 with payloads 0x01, 0x22, 0x43, 0x7F, cs high for 1 sclk period between frames → four wr_stb pulses and correct reg_bank. With SPI_SLAVE_ERR_CNT_EN: two error frames give err_cnt=2, then a write to addr 4 gives err_cnt=0.

Source files
------------

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave serving a small register bank, all logic in the sysclk domain.
// Define SPI_SLAVE_ERR_CNT_EN to add the saturating err_cnt output, cleared by a write to address NUM_REGS.
module spi_slave_regs #(
   parameter int CMD_BITS     = 1,
   parameter int ADDR_BITS    = 8,
   parameter int PAYLOAD_BITS = 7,
   parameter int NUM_REGS     = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                             sysclk,
   input  logic                             rst,
   input  logic                             sclk,
   input  logic                             cs,
   input  logic                             mosi,
   output logic                             miso,
   output logic [NUM_REGS*PAYLOAD_BITS-1:0] reg_bank,
   output logic                             wr_stb,
   output logic [ADDR_BITS-1:0]             wr_addr,
   output logic [PAYLOAD_BITS-1:0]          wr_data,
   output logic                             frame_done,
   output logic                             frame_err
`ifdef SPI_SLAVE_ERR_CNT_EN
   ,
   output logic [7:0]                       err_cnt
`endif
);
   localparam int MAXB = (CMD_BITS > ADDR_BITS) ? ((CMD_BITS > PAYLOAD_BITS) ? CMD_BITS : PAYLOAD_BITS)
                                                : ((ADDR_BITS > PAYLOAD_BITS) ? ADDR_BITS : PAYLOAD_BITS);
   localparam int CW = $clog2(MAXB + 1);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
   state_t state, nstate;
   logic [SYNC_STAGES:0] sclk_sr, cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
   logic shifting, abort, last, load_d, is_wr, addr_ok, clr_hit;
   logic [CW-1:0] cnt;
   logic [CMD_BITS-1:0] cmd_sr;
   logic [ADDR_BITS-1:0] addr_sr, addr_nx;
   logic [PAYLOAD_BITS-1:0] data_sr, tx_sr, tx_sh;
   logic [PAYLOAD_BITS-1:0] regs [NUM_REGS];

   assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_sr[SYNC_STAGES];
   assign cs_rise   = cs_sr[SYNC_STAGES-1] & ~cs_sr[SYNC_STAGES];
   assign cs_fall   = ~cs_sr[SYNC_STAGES-1] & cs_sr[SYNC_STAGES];
   assign mosi_s    = mosi_sr[SYNC_STAGES-1];
   assign shifting  = state inside {CMD, ADDR, DATA};
   assign abort     = shifting & cs_rise;
   assign last      = (state == CMD)  ? cnt == CW'(CMD_BITS - 1)
                    : (state == ADDR) ? cnt == CW'(ADDR_BITS - 1)
                    : cnt == CW'(PAYLOAD_BITS - 1);
   assign addr_nx   = ADDR_BITS'({addr_sr, mosi_s});
   assign tx_sh     = tx_sr << 1;
   assign is_wr     = cmd_sr == CMD_BITS'(1);
   assign addr_ok   = addr_sr < ADDR_BITS'(NUM_REGS);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
      assign reg_bank[i*PAYLOAD_BITS +: PAYLOAD_BITS] = regs[i];
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sclk_sr <= '0;
         cs_sr   <= '1;
         mosi_sr <= '0;
         state   <= IDLE;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], sclk};
         cs_sr   <= {cs_sr[SYNC_STAGES-1:0], cs};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         state   <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    nstate = cs_fall ? CMD : IDLE;
         CMD:     nstate = abort ? IDLE : (sclk_rise && last) ? ADDR : CMD;
         ADDR:    nstate = abort ? IDLE : (sclk_rise && last) ? DATA : ADDR;
         DATA:    nstate = abort ? IDLE : (sclk_rise && last) ? DONE : DATA;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         cnt        <= '0;
         cmd_sr     <= '0;
         addr_sr    <= '0;
         data_sr    <= '0;
         tx_sr      <= '0;
         load_d     <= 1'b0;
         miso       <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         wr_stb     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= abort;
         load_d     <= 1'b0;
         cnt        <= (state != nstate) ? '0 : (shifting && sclk_rise) ? cnt + 1'b1 : cnt;
         if (load_d) miso <= tx_sr[PAYLOAD_BITS-1];
         case (state)
            IDLE: begin
               cmd_sr  <= '0;
               addr_sr <= '0;
               data_sr <= '0;
               tx_sr   <= '0;
               miso    <= 1'b0;
            end
            CMD: if (sclk_rise && !abort) cmd_sr <= CMD_BITS'({cmd_sr, mosi_s});
            ADDR: if (sclk_rise && !abort) begin
               addr_sr <= addr_nx;
               if (last) begin
                  tx_sr  <= (!is_wr && addr_nx < ADDR_BITS'(NUM_REGS)) ? regs[addr_nx[IW-1:0]] : '0;
                  load_d <= 1'b1;
               end
            end
            DATA: begin
               if (sclk_rise && !abort) data_sr <= PAYLOAD_BITS'({data_sr, mosi_s});
               // the fall closing the last address bit must keep the MSB on miso
               if (sclk_fall && !abort && cnt != '0) begin
                  tx_sr <= tx_sh;
                  miso  <= tx_sh[PAYLOAD_BITS-1];
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               miso       <= 1'b0;
               if (addr_ok && is_wr) begin
                  regs[addr_sr[IW-1:0]] <= data_sr;
                  wr_stb  <= 1'b1;
                  wr_addr <= addr_sr;
                  wr_data <= data_sr;
               end else if (!addr_ok && !clr_hit) frame_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_SLAVE_ERR_CNT_EN
   assign clr_hit = (state == DONE) && is_wr && addr_sr == ADDR_BITS'(NUM_REGS);
   always_ff @(posedge sysclk) begin
      if (rst) err_cnt <= '0;
      else if (clr_hit) err_cnt <= '0;
      else if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
   end
`else
   assign clr_hit = 1'b0;
`endif
endmodule
